// File: rtl/fetch_btb.sv
// fetch_btb: 2-way set-associative BTB, one branch record per 32-byte fetch bundle, 1-cycle lookup.
// Define BTB_WR_BYPASS_EN to forward a same-cycle write to a lookup of the same set and tag.
module fetch_btb #(
  parameter int SETS  = 64,
  parameter int TAG_W = 20
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        lkp_req_i,
  input  logic [63:0] lkp_pc_i,
  input  logic        wr_en_i,
  input  logic [63:0] wr_pc_i,
  input  logic [2:0]  wr_pos_i,
  input  logic [1:0]  wr_typ_i,
  input  logic [63:0] wr_tar_i,
  output logic        pred_hit_o,
  output logic [2:0]  pred_pos_o,
  output logic [1:0]  pred_typ_o,
  output logic [63:0] pred_tar_o
);
  localparam int IDX_W = $clog2(SETS);
  logic [SETS-1:0]  valid [2];
  logic [SETS-1:0]  lru;
  logic [TAG_W-1:0] tag_m [2][SETS];
  logic [2:0]       pos_m [2][SETS];
  logic [1:0]       typ_m [2][SETS];
  logic [63:0]      tar_m [2][SETS];
  logic [IDX_W-1:0] l_idx, w_idx;
  logic [TAG_W-1:0] l_tag, w_tag;
  logic [2:0]       slot;
  logic [1:0]       l_hit, w_hit;
  logic             l_way, w_way, lk, do_wr, byp;
  logic             nxt_hit;
  logic [2:0]       nxt_pos;
  logic [1:0]       nxt_typ;
  logic [63:0]      nxt_tar;
  logic             unused;
  assign l_idx = lkp_pc_i[5 +: IDX_W];
  assign l_tag = lkp_pc_i[5+IDX_W +: TAG_W];
  assign slot  = lkp_pc_i[4:2];
  assign w_idx = wr_pc_i[5 +: IDX_W];
  assign w_tag = wr_pc_i[5+IDX_W +: TAG_W];
  assign unused = ^{lkp_pc_i[1:0], lkp_pc_i[63:5+IDX_W+TAG_W], wr_pc_i[4:0], wr_pc_i[63:5+IDX_W+TAG_W]};
  assign lk    = lkp_req_i && !flush_i;
  assign do_wr = wr_en_i && !flush_i;
  always_comb begin
    l_hit = '0;
    w_hit = '0;
    for (int i = 0; i < 2; i++) begin
      l_hit[i] = valid[i][l_idx] && tag_m[i][l_idx] == l_tag && pos_m[i][l_idx] >= slot;
      w_hit[i] = valid[i][w_idx] && tag_m[i][w_idx] == w_tag;
    end
  end
  // way 0 wins a (duplicate-write) double hit
  assign l_way = !l_hit[0];
  assign w_way = w_hit[0] ? 1'b0 :
                 w_hit[1] ? 1'b1 :
                 !valid[0][w_idx] ? 1'b0 :
                 !valid[1][w_idx] ? 1'b1 : lru[w_idx];
`ifdef BTB_WR_BYPASS_EN
  assign byp = do_wr && lkp_req_i && w_idx == l_idx && w_tag == l_tag;
`else
  assign byp = 1'b0;
`endif
  always_comb begin
    nxt_hit = lk && (byp ? wr_pos_i >= slot : |l_hit);
    nxt_pos = !nxt_hit ? 3'd0  : byp ? wr_pos_i : pos_m[l_way][l_idx];
    nxt_typ = !nxt_hit ? 2'd0  : byp ? wr_typ_i : typ_m[l_way][l_idx];
    nxt_tar = !nxt_hit ? 64'd0 : byp ? wr_tar_i : tar_m[l_way][l_idx];
  end
  // the write's LRU update is issued last so it overrides a same-set lookup
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid[0] <= '0;
      valid[1] <= '0;
      lru      <= '0;
    end else begin
      if (flush_i) begin
        valid[0] <= '0;
        valid[1] <= '0;
      end
      if (lk && |l_hit) lru[l_idx] <= ~l_way;
      if (do_wr) begin
        valid[w_way][w_idx] <= 1'b1;
        lru[w_idx]          <= ~w_way;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i && do_wr) begin
      tag_m[w_way][w_idx] <= w_tag;
      pos_m[w_way][w_idx] <= wr_pos_i;
      typ_m[w_way][w_idx] <= wr_typ_i;
      tar_m[w_way][w_idx] <= wr_tar_i;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pred_hit_o <= 1'b0;
      pred_pos_o <= '0;
      pred_typ_o <= '0;
      pred_tar_o <= '0;
    end else begin
      pred_hit_o <= nxt_hit;
      pred_pos_o <= nxt_pos;
      pred_typ_o <= nxt_typ;
      pred_tar_o <= nxt_tar;
    end
  end
endmodule

// File: tb/tb_fetch_btb.sv
// tb_fetch_btb: scoreboard bench for fetch_btb; expected lookup results queued at issue, observed results queued one cycle later.
module tb_fetch_btb;
  typedef logic [69:0] res_t;
  logic clk = 1'b0;
  logic rst = 1'b1, flush = 1'b0, lreq = 1'b0, we = 1'b0;
  logic [63:0] lpc = '0, wpc = '0, wtar = '0;
  logic [2:0] wpos = '0;
  logic [1:0] wtyp = '0;
  logic hit;
  logic [2:0] pos;
  logic [1:0] typ;
  logic [63:0] tar;
  logic req_d = 1'b0;
  res_t exp_q [$];
  res_t obs_q [$];
  string nm_q [$];
  int passed = 0, total = 0;
  fetch_btb dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .lkp_req_i(lreq), .lkp_pc_i(lpc),
    .wr_en_i(we), .wr_pc_i(wpc), .wr_pos_i(wpos), .wr_typ_i(wtyp), .wr_tar_i(wtar),
    .pred_hit_o(hit), .pred_pos_o(pos), .pred_typ_o(typ), .pred_tar_o(tar)
  );
  always #5 clk = ~clk;
  always @(posedge clk) req_d <= lreq;
  always @(negedge clk) if (req_d) obs_q.push_back({hit, pos, typ, tar});
  function automatic res_t res(input logic h, input logic [2:0] p, input logic [1:0] t, input logic [63:0] a);
    return {h, p, t, a};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0; lreq = 1'b0; we = 1'b0;
  endtask
  task automatic wr(input logic [63:0] pc, input logic [2:0] p, input logic [1:0] t, input logic [63:0] a);
    we = 1'b1; wpc = pc; wpos = p; wtyp = t; wtar = a;
  endtask
  task automatic look(input logic [63:0] pc, input res_t e, input string n);
    lreq = 1'b1; lpc = pc; exp_q.push_back(e); nm_q.push_back(n);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    total++;
    if ({hit, pos, typ, tar} !== res(1'b0, 3'd0, 2'd0, 64'd0))
      $display("FAIL reset_outputs: got %h required %h", {hit, pos, typ, tar}, res(1'b0, 3'd0, 2'd0, 64'd0));
    else passed++;
    look(64'h1000, res(1'b0, 3'd0, 2'd0, 64'd0), "reset_empty");
    tick();
    @(negedge clk); #1;
    while (exp_q.size() != 0) begin
      res_t e, o; string n;
      e = exp_q.pop_front(); n = nm_q.pop_front(); total++;
      if (obs_q.size() == 0) $display("FAIL %s: no output, required %h", n, e);
      else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL %s: got %h required %h", n, o, e); else passed++; end
    end
  endtask
  task automatic test_basic();
    wr(64'h1000, 3'd3, 2'd1, 64'h2000);
    tick();
    look(64'h1000, res(1'b1, 3'd3, 2'd1, 64'h2000), "basic_hit");
    tick();
    look(64'h1010, res(1'b0, 3'd0, 2'd0, 64'd0), "slot4_miss");
    tick();
    look(64'h100C, res(1'b1, 3'd3, 2'd1, 64'h2000), "slot3_hit");
    tick();
    look(64'h1003, res(1'b1, 3'd3, 2'd1, 64'h2000), "slot0_unaligned_hit");
    tick();
    @(negedge clk); #1;
    while (exp_q.size() != 0) begin
      res_t e, o; string n;
      e = exp_q.pop_front(); n = nm_q.pop_front(); total++;
      if (obs_q.size() == 0) $display("FAIL %s: no output, required %h", n, e);
      else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL %s: got %h required %h", n, o, e); else passed++; end
    end
  endtask
  // A, B, C share set 1 with tags 0, 1, 2
  task automatic test_fill();
    wr(64'h0020, 3'd7, 2'd0, 64'hA000);
    tick();
    wr(64'h0820, 3'd7, 2'd2, 64'hB000);
    tick();
    look(64'h0020, res(1'b1, 3'd7, 2'd0, 64'hA000), "fill_A_first");
    tick();
    wr(64'h1020, 3'd7, 2'd3, 64'hC000);
    tick();
    look(64'h0020, res(1'b1, 3'd7, 2'd0, 64'hA000), "fill_A_kept");
    tick();
    look(64'h0820, res(1'b0, 3'd0, 2'd0, 64'd0), "fill_B_evicted");
    tick();
    look(64'h1020, res(1'b1, 3'd7, 2'd3, 64'hC000), "fill_C_hit");
    tick();
    @(negedge clk); #1;
    while (exp_q.size() != 0) begin
      res_t e, o; string n;
      e = exp_q.pop_front(); n = nm_q.pop_front(); total++;
      if (obs_q.size() == 0) $display("FAIL %s: no output, required %h", n, e);
      else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL %s: got %h required %h", n, o, e); else passed++; end
    end
  endtask
  // LRU points at C's way before the rewrite, so only a tag-hit overwrite keeps C
  task automatic test_rewrite();
    look(64'h0020, res(1'b1, 3'd7, 2'd0, 64'hA000), "rewrite_A_before");
    tick();
    wr(64'h0020, 3'd5, 2'd1, 64'h3000);
    tick();
    look(64'h0020, res(1'b1, 3'd5, 2'd1, 64'h3000), "rewrite_A_new");
    tick();
    look(64'h1020, res(1'b1, 3'd7, 2'd3, 64'hC000), "rewrite_C_resident");
    tick();
    look(64'h0038, res(1'b0, 3'd0, 2'd0, 64'd0), "rewrite_A_slot6_miss");
    tick();
    @(negedge clk); #1;
    while (exp_q.size() != 0) begin
      res_t e, o; string n;
      e = exp_q.pop_front(); n = nm_q.pop_front(); total++;
      if (obs_q.size() == 0) $display("FAIL %s: no output, required %h", n, e);
      else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL %s: got %h required %h", n, o, e); else passed++; end
    end
  endtask
  task automatic test_flush_reset();
    wr(64'h0040, 3'd2, 2'd1, 64'hE000);
    tick();
    look(64'h0040, res(1'b1, 3'd2, 2'd1, 64'hE000), "flush_E_before");
    tick();
    flush = 1'b1;
    wr(64'h2040, 3'd4, 2'd2, 64'hD000);
    look(64'h0020, res(1'b0, 3'd0, 2'd0, 64'd0), "flush_same_cycle_lookup");
    tick();
    look(64'h0020, res(1'b0, 3'd0, 2'd0, 64'd0), "flush_A_miss");
    tick();
    look(64'h1020, res(1'b0, 3'd0, 2'd0, 64'd0), "flush_C_miss");
    tick();
    look(64'h2040, res(1'b0, 3'd0, 2'd0, 64'd0), "flush_D_dropped");
    tick();
    look(64'h0040, res(1'b0, 3'd0, 2'd0, 64'd0), "flush_E_miss");
    tick();
    wr(64'h5000, 3'd1, 2'd2, 64'hF000);
    tick();
    look(64'h5000, res(1'b1, 3'd1, 2'd2, 64'hF000), "rst_F_before");
    tick();
    rst = 1'b1;
    wr(64'h6000, 3'd7, 2'd1, 64'h6666);
    look(64'h5000, res(1'b0, 3'd0, 2'd0, 64'd0), "rst_outputs_zero");
    tick();
    look(64'h5000, res(1'b0, 3'd0, 2'd0, 64'd0), "rst_F_miss");
    tick();
    look(64'h6000, res(1'b0, 3'd0, 2'd0, 64'd0), "rst_G_dropped");
    tick();
    look(64'h1000, res(1'b0, 3'd0, 2'd0, 64'd0), "rst_basic_miss");
    tick();
    @(negedge clk); #1;
    while (exp_q.size() != 0) begin
      res_t e, o; string n;
      e = exp_q.pop_front(); n = nm_q.pop_front(); total++;
      if (obs_q.size() == 0) $display("FAIL %s: no output, required %h", n, e);
      else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL %s: got %h required %h", n, o, e); else passed++; end
    end
  endtask
  task automatic test_same_cycle();
    wr(64'h4000, 3'd0, 2'd2, 64'h4444);
`ifdef BTB_WR_BYPASS_EN
    look(64'h4000, res(1'b1, 3'd0, 2'd2, 64'h4444), "same_cycle_bypass");
`else
    look(64'h4000, res(1'b0, 3'd0, 2'd0, 64'd0), "same_cycle_prewrite");
`endif
    tick();
    look(64'h4000, res(1'b1, 3'd0, 2'd2, 64'h4444), "same_cycle_followup");
    tick();
    @(negedge clk); #1;
    while (exp_q.size() != 0) begin
      res_t e, o; string n;
      e = exp_q.pop_front(); n = nm_q.pop_front(); total++;
      if (obs_q.size() == 0) $display("FAIL %s: no output, required %h", n, e);
      else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL %s: got %h required %h", n, o, e); else passed++; end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_rewrite();
    test_flush_reset();
    test_same_cycle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
